// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared microcode ALU opcode encoding and FLAGS layout
package alu_op_sequencer_pkg;

  localparam int unsigned MC_ALUOp_t_BITS = 5;

  typedef enum logic [MC_ALUOp_t_BITS-1:0] {
    ALUOp_SELA = 5'd0,
    ALUOp_ADD  = 5'd1,
    ALUOp_SUB  = 5'd2,
    ALUOp_AND  = 5'd3,
    ALUOp_OR   = 5'd4,
    ALUOp_XOR  = 5'd5,
    ALUOp_SHL  = 5'd6,
    ALUOp_SHR  = 5'd7,
    ALUOp_SAR  = 5'd8,
    ALUOp_ROL  = 5'd9,
    ALUOp_ROR  = 5'd10,
    ALUOp_DIV  = 5'd11,
    ALUOp_IDIV = 5'd12
  } ALUOp_t;

  // Bit positions within the 16-bit architectural FLAGS register.
  localparam int unsigned CF_IDX = 0;
  localparam int unsigned PF_IDX = 2;
  localparam int unsigned AF_IDX = 4;
  localparam int unsigned ZF_IDX = 6;
  localparam int unsigned SF_IDX = 7;
  localparam int unsigned OF_IDX = 11;

  localparam logic [15:0] FLAGS_RESET = 16'h0002;

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives the combinational ALU, iterates shifts, owns FLAGS
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter logic [15:0] FLAGS_RESET = alu_op_sequencer_pkg::FLAGS_RESET,
  parameter int unsigned MAX_STEPS   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       ready,
  input  logic [MC_ALUOp_t_BITS-1:0] op,
  input  logic [15:0]                a,
  input  logic [15:0]                b,
  input  logic                       is_8_bit,
  input  logic                       multibit_shift,
  input  logic [4:0]                 shift_count,
  output logic                       done,
  output logic                       error,
  output logic [31:0]                result,
  output logic [15:0]                flags,
  output logic [15:0]                alu_a,
  output logic [15:0]                alu_b,
  output logic [MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  output logic                       alu_multibit_shift,
  output logic [4:0]                 alu_shift_count,
  output logic [15:0]                alu_flags_in,
  input  logic [31:0]                alu_out,
  input  logic [15:0]                alu_flags_out,
  input  logic                       alu_busy
);

  localparam int unsigned       STEP_W    = $clog2(MAX_STEPS) + 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [STEP_W-1:0]            step_q, step_d;
  logic                         done_q, done_d;
  logic                         error_q, error_d;
  logic [31:0]                  result_q, result_d;
  logic [15:0]                  flags_q, flags_d;
  logic [15:0]                  alu_a_q, alu_a_d;
  logic [15:0]                  alu_b_q, alu_b_d;
  logic [MC_ALUOp_t_BITS-1:0]   alu_op_q, alu_op_d;
  logic                         is8_q, is8_d;
  logic                         multi_q, multi_d;
  logic [4:0]                   cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    is8_d    = is8_q;
    multi_d  = multi_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          alu_a_d  = a;
          alu_b_d  = b;
          alu_op_d = op;
          is8_d    = is_8_bit;
          multi_d  = multibit_shift;
          cnt_d    = shift_count;
          step_d   = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        flags_d = alu_flags_out;
        step_d  = step_q + 1'b1;
        if (!alu_busy) begin
          result_d = alu_out;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (step_q == STEP_LAST) begin
          // A runaway ALU is cut off; the partial result is still reported.
          result_d = alu_out;
          done_d   = 1'b1;
          error_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          alu_a_d = alu_out[15:0];
          cnt_d   = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= FLAGS_RESET;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALUOp_SELA;
      is8_q    <= 1'b0;
      multi_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      is8_q    <= is8_d;
      multi_q  <= multi_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready              = (state_q == IDLE);
  assign done               = done_q;
  assign error              = error_q;
  assign result             = result_q;
  assign flags              = flags_q;
  assign alu_flags_in       = flags_q;
  assign alu_a              = alu_a_q;
  assign alu_b              = alu_b_q;
  assign alu_op             = alu_op_q;
  assign alu_is_8_bit       = is8_q;
  assign alu_multibit_shift = multi_q;
  assign alu_shift_count    = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench with a behavioural ALU and result scoreboard
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic [4:0]  op;
  logic [15:0] a, b;
  logic        is_8_bit, multibit_shift;
  logic [4:0]  shift_count;
  logic        done, error;
  logic [31:0] result;
  logic [15:0] flags;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic        alu_is_8_bit, alu_multibit_shift;
  logic [4:0]  alu_shift_count;
  logic [15:0] alu_flags_in;
  logic [31:0] alu_out;
  logic [15:0] alu_flags_out;
  logic        alu_busy;
  logic        force_busy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [15:0] flg;
    int          lat;
  } exp_t;
  exp_t sb[$];

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .op(op),
    .a(a), .b(b), .is_8_bit(is_8_bit), .multibit_shift(multibit_shift),
    .shift_count(shift_count), .done(done), .error(error), .result(result),
    .flags(flags), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_is_8_bit(alu_is_8_bit), .alu_multibit_shift(alu_multibit_shift),
    .alu_shift_count(alu_shift_count), .alu_flags_in(alu_flags_in),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out), .alu_busy(alu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Behavioural ALU: one bit position per step for shifts/rotates.
  logic [15:0] m_res;
  logic [16:0] m_sum;
  logic        m_cf, m_of, m_upd, m_shift, m_zf, m_sf;
  always_comb begin
    m_res = alu_a; m_sum = '0; m_cf = 1'b0; m_of = 1'b0; m_upd = 1'b0; m_shift = 1'b0;
    case (alu_op)
      ALUOp_ADD: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = m_sum[15:0]; m_cf = m_sum[16];
        m_of = (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]); m_upd = 1'b1;
      end
      ALUOp_SHL: begin
        m_cf = alu_is_8_bit ? alu_a[7] : alu_a[15];
        m_res = alu_a << 1; m_upd = 1'b1; m_shift = 1'b1;
      end
      ALUOp_SHR: begin
        m_res = alu_is_8_bit ? {9'h0, alu_a[7:1]} : (alu_a >> 1);
        m_cf = alu_a[0]; m_upd = 1'b1; m_shift = 1'b1;
      end
      ALUOp_ROL: begin
        m_res = alu_is_8_bit ? {8'h0, alu_a[6:0], alu_a[7]} : {alu_a[14:0], alu_a[15]};
        m_cf = m_res[0]; m_upd = 1'b1; m_shift = 1'b1;
      end
      ALUOp_DIV, ALUOp_IDIV: m_res = 16'h0000;
      default: m_res = alu_a;
    endcase
    if (alu_is_8_bit) m_res[15:8] = 8'h00;
    if (m_shift && alu_multibit_shift && alu_shift_count == 5'd0) begin
      m_res = alu_a; m_upd = 1'b0;
    end
    m_zf = alu_is_8_bit ? (m_res[7:0] == 8'h00) : (m_res == 16'h0000);
    m_sf = alu_is_8_bit ? m_res[7] : m_res[15];
    alu_busy = force_busy || (m_shift && alu_multibit_shift && alu_shift_count > 5'd1);
    alu_out = {16'h0000, m_res};
    alu_flags_out = alu_flags_in;
    if (m_upd) begin
      alu_flags_out = alu_flags_in & ~16'h08C1;
      alu_flags_out[CF_IDX] = m_cf;
      alu_flags_out[ZF_IDX] = m_zf;
      alu_flags_out[SF_IDX] = m_sf;
      alu_flags_out[OF_IDX] = m_of;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic b8, input logic ms, input logic [4:0] cnt);
    op = op_v; a = a_v; b = b_v; is_8_bit = b8; multibit_shift = ms; shift_count = cnt;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_op(input logic [31:0] res, input logic err, input logic [15:0] flg, input int lat);
    exp_t e;
    e.res = res; e.err = err; e.flg = flg; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called in the cycle after the accept edge (cycle n0); runs until done, then checks it.
  task automatic wait_done(input int n0, input string tag);
    int n;
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
    if (done === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_error"}, error, e.err);
      chk({tag, "_flags"}, flags, e.flg);
      chk({tag, "_ready"}, ready, 1'b1);
    end
    step();
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; force_busy = 1'b0;
    op = '0; a = '0; b = '0; is_8_bit = 1'b0; multibit_shift = 1'b0; shift_count = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", flags, 16'h0002);
    chk("rst_flags_in", alu_flags_in, 16'h0002);
    chk("rst_alu_a", alu_a, 16'h0);
    chk("rst_alu_op", alu_op, ALUOp_SELA);
    chk("rst_alu_cnt", alu_shift_count, 5'd0);

    expect_op(32'h0000_8000, 1'b0, 16'h0882, 2);
    issue(ALUOp_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 5'd0);
    chk("add_ready_low", ready, 1'b0);
    wait_done(1, "add");

    expect_op(32'h0000_0008, 1'b0, 16'h0002, 4);
    issue(ALUOp_SHL, 16'h0081, 16'h0000, 1'b1, 1'b1, 5'd3);
    chk("shl_cnt3", alu_shift_count, 5'd3);
    step();
    chk("shl_cnt2", alu_shift_count, 5'd2);
    step();
    chk("shl_cnt1", alu_shift_count, 5'd1);
    wait_done(3, "shl8");

    expect_op(32'h0000_0001, 1'b0, 16'h0003, 2);
    issue(ALUOp_SHR, 16'h0003, 16'h0000, 1'b0, 1'b0, 5'd1);
    wait_done(1, "shr1");

    expect_op(32'h0000_1234, 1'b0, 16'h0003, 2);
    issue(ALUOp_ROL, 16'h1234, 16'h0000, 1'b0, 1'b1, 5'd0);
    wait_done(1, "rol0");

    expect_op(32'h0000_0000, 1'b0, 16'h0003, 2);
    issue(ALUOp_DIV, 16'd100, 16'd7, 1'b0, 1'b0, 5'd0);
    wait_done(1, "div");

    dc = done_cnt;
    issue(ALUOp_SHR, 16'h00F0, 16'h0000, 1'b0, 1'b1, 5'd5);
    step();
    reset = 1'b1;
    step();
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_flags", flags, 16'h0002);
    chk("abort_result", result, 32'h0);
    chk("abort_alu_a", alu_a, 16'h0);
    chk("abort_alu_cnt", alu_shift_count, 5'd0);
    reset = 1'b0;
    repeat (8) step();
    chk("abort_no_done", done_cnt, dc);

    dc = done_cnt;
    expect_op(32'h0000_0010, 1'b0, 16'h0002, 5);
    issue(ALUOp_SHL, 16'h0001, 16'h0000, 1'b0, 1'b1, 5'd4);
    step();
    op = ALUOp_ADD; a = 16'h0001; b = 16'h0001; multibit_shift = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3, "midstart");
    repeat (6) step();
    chk("midstart_one_done", done_cnt - dc, 1);

    force_busy = 1'b1;
    expect_op(32'h0000_5555, 1'b1, 16'h0002, 33);
    issue(ALUOp_SELA, 16'h5555, 16'h0000, 1'b0, 1'b0, 5'd0);
    wait_done(1, "steplimit");
    force_busy = 1'b0;
    step();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Microcode-side initiator for the combinational ALU. It accepts one ALU operation per request, drives the ALU's operand, opcode and flag ports, and iterates multi-bit shifts and rotates while the ALU reports busy. It owns the architectural FLAGS register, latches the 32-bit result, and signals completion to the microcode sequencer.

## Interface
Parameters:
- `FLAGS_RESET`, 16'h0002: FLAGS value after reset (reserved bit 1 set).
- `MAX_STEPS`, 32: step-count limit after which an operation is forcibly terminated.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted when `ready`=1.
- `ready`  out  1  high only in IDLE.
- `op`  in  `MC_ALUOp_t_BITS`  operation.
- `a`, `b`  in  16  operands.
- `is_8_bit`  in  1  byte operation.
- `multibit_shift`  in  1  shift by `shift_count` rather than by 1.
- `shift_count`  in  5  shift/rotate count (already masked to 0..31).
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`; set when the step limit was hit.
- `result`  out  32  last completed result; held until the next completion.
- `flags`  out  16  architectural FLAGS register.
- `alu_a`, `alu_b`  out  16  ALU operands.
- `alu_op`  out  `MC_ALUOp_t_BITS`  ALU opcode.
- `alu_is_8_bit`, `alu_multibit_shift`  out  1  ALU mode.
- `alu_shift_count`  out  5  remaining count.
- `alu_flags_in`  out  16  always equals `flags`.
- `alu_out`  in  32  ALU result.
- `alu_flags_out`  in  16  ALU flags.
- `alu_busy`  in  1  ALU requires another step.

## Operation
- States are IDLE and EXEC.
- IDLE:
  - `ready`=1.
  - On `start`, register `op`, `a`, `b`, `is_8_bit`, `multibit_shift` and `shift_count` into `alu_*`, clear the step counter, and go to EXEC.
- EXEC, every cycle:
  - `flags` <= `alu_flags_out`.
  - Increment the step counter.
- EXEC with `alu_busy`=1 (step taken):
  - `alu_a` <= `alu_out[15:0]`.
  - `alu_shift_count` <= `alu_shift_count` − 1.
  - Stay in EXEC.
- EXEC with `alu_busy`=0:
  - `result` <= `alu_out`.
  - Pulse `done` next cycle with `error`=0.
  - Return to IDLE.
- Step limit: if the step counter reaches `MAX_STEPS` while `alu_busy`=1:
  - `result` <= `alu_out`; flags are still written from `alu_flags_out`.
  - `done`=1, `error`=1.
  - Return to IDLE.
- Count 0 with `multibit_shift`=1: the ALU returns busy=0 and flags unchanged, so the operation completes in one EXEC cycle with `flags` unchanged.
- DIV/IDIV must not be issued here. If issued, they complete in one step with `result`=0 and `flags` unchanged.
- `start` while `ready`=0 is ignored, not queued.
- 8-bit feedback passes all of `alu_out[15:0]`; the ALU is responsible for ignoring the upper byte.

## Timing
Reset values:
- `ready`=1, `done`=0, `error`=0.
- `result`=0, `flags`=`FLAGS_RESET`.
- `alu_*` outputs all 0; `alu_op`=`ALUOp_SELA`.

Latency, with `start` accepted at cycle 0:
- A single-step operation finishes at the end of cycle 1; `done` is high in cycle 2.
- A shift of count N≥1 takes N EXEC cycles; `done` is high in cycle N+1.
- `ready` returns high in the same cycle as `done`, so back-to-back throughput is one operation per (latency) cycles.

Reset asserted at any point, including mid-shift:
- Returns to IDLE next edge and all outputs go to their reset values.
- No `done` is issued for the aborted operation.
- `flags` is not preserved.

## Structure
- Shared microcode package (existing): `ALUOp` enumeration, `MC_ALUOp_t_BITS`, flag index constants (`CF_IDX`, `OF_IDX`, …) and `FLAGS_RESET`.
- Local: state typedef {IDLE, EXEC} and a step counter of $clog2(`MAX_STEPS`)+1 bits.
- No sub-module: the ALU is instantiated beside this block by the parent, not inside it.

## Test plan
- ADD, 16-bit, a=16'h7FFF, b=16'h0001 -> `done` in cycle 2, `result`=32'h0000_8000, OF=1, SF=1, CF=0.
- SHL, 8-bit, a=16'h0081, count 3, multibit -> 3 EXEC cycles, `done` in cycle 4, `result[7:0]`=8'h08, CF=0, `alu_shift_count` observed 3→2→1.
- ROL, count 0, multibit, `flags`=16'h0003 -> `done` in cycle 2, `flags`=16'h0003, `result[15:0]`=`a`.
- Reset asserted during the second step of a count-5 SHR -> IDLE next cycle, no `done`, `flags`=16'h0002, `ready`=1.
- `start` pulsed mid-operation with op=ADD -> ignored; exactly one `done` pulse, for the original op.
- Bench ALU model holding `alu_busy`=1 -> `done`=1 with `error`=1 after 32 EXEC cycles; `ready`=1 in the same cycle.
